// File: rtl/spi_sram_pkg.sv
// Shared constants, state encoding and write-packing helpers for the SPI SRAM link.
package spi_sram_pkg;

  localparam logic [7:0] SPI_WRITE_CMD = 8'h02;
  localparam logic [7:0] SPI_READ_CMD  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RFETCH,
    ST_RDATA,
    ST_WDATA,
    ST_COMMIT,
    ST_IGNORE
  } tgt_state_e;

  // Byte enables for n complete bytes, filled from the top byte downwards.
  function automatic logic [3:0] wstrb_of(input logic [2:0] nbytes);
    logic [3:0] s;
    case (nbytes)
      3'd1:    s = 4'b1000;
      3'd2:    s = 4'b1100;
      3'd3:    s = 4'b1110;
      3'd4:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Move the nbits most recently shifted bits to the top of the word and keep
  // only the complete bytes; a trailing partial byte falls below the mask.
  function automatic logic [31:0] walign(input logic [31:0] sr, input logic [5:0] nbits);
    logic [5:0]  sh;
    logic [31:0] mask;
    sh   = 6'd32 - nbits;
    mask = ~(32'hFFFF_FFFF >> {nbits[5:3], 3'b000});
    return (sr << sh) & mask;
  endfunction

endpackage

// File: rtl/spi_sram_target_edge_sync.sv
// One SPI input: synchronizer chain plus optional rise/fall detect against one extra flop.
module spi_edge_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw pin through the synchronizer chain.
  always_ff @(posedge clk_i) begin
    if (reset_i) chain_q <= '0;
    else         chain_q <= STAGES'({chain_q, d_i});
  end

  assign sync_o = chain_q[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic prev_q;
    // Remember last synchronized level so edges show up as one-cycle pulses.
    always_ff @(posedge clk_i) begin
      if (reset_i) prev_q <= 1'b0;
      else         prev_q <= sync_o;
    end
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 target emulating a serial SRAM (0x02 write / 0x03 read) onto a word-memory port.
module spi_sram_target
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sclk_i,
  input  logic              ce_i,
  input  logic              si_i,
  output logic              so_o,
  output logic              so_oe_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              cmd_err_o
);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ce_rise, ce_fall, ce_lvl_unused;
  logic si_s, si_rise_unused, si_fall_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(sclk_i),
    .sync_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));

  spi_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_ce (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(ce_i),
    .sync_o(ce_lvl_unused), .rise_o(ce_rise), .fall_o(ce_fall));

  spi_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_si (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(si_i),
    .sync_o(si_s), .rise_o(si_rise_unused), .fall_o(si_fall_unused));

  tgt_state_e        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [31:0]       sr_q, sr_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       rd_q, rd_d;
  logic              so_q, so_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              cmd_err_q, cmd_err_d;
  logic              mem_req, mem_we;

  logic [7:0] cmd_w;
  logic       last_cmd, last_addr, shift_en;

  // Command byte as it stands once the current sampled bit is included.
  assign cmd_w     = {sr_q[6:0], si_s};
  assign last_cmd  = sclk_rise && (cnt_q == 6'd7);
  assign last_addr = sclk_rise && (cnt_q == 6'(ADDR_W - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode; a ce fall ends any transaction except a pending commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ce_rise) state_d = ST_CMD;
      ST_CMD:    if (last_cmd)
                   state_d = (cmd_w == SPI_WRITE_CMD || cmd_w == SPI_READ_CMD) ? ST_ADDR : ST_IGNORE;
      ST_ADDR:   if (last_addr) state_d = is_wr_q ? ST_WDATA : ST_RFETCH;
      ST_RFETCH: if (mem_ack_i) state_d = ST_RDATA;
      ST_COMMIT: if (mem_ack_i) state_d = ST_IDLE;
      default:   ;
    endcase
    if (ce_fall && state_q != ST_IDLE && state_q != ST_COMMIT)
      state_d = (state_q == ST_WDATA && cnt_q >= 6'd8) ? ST_COMMIT : ST_IDLE;
  end

  // Memory handshake and error pulse decoded from the current state.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    cmd_err_d = 1'b0;
    case (state_q)
      ST_CMD:    if (state_d == ST_IGNORE) cmd_err_d = 1'b1;
      ST_RFETCH: begin
        mem_req = 1'b1;
        // Read word not back before the first output bit is due.
        if (sclk_fall && !mem_ack_i && !ce_fall) cmd_err_d = 1'b1;
      end
      ST_COMMIT: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next values: serial shift-in, address/write capture, read shift-out.
  always_comb begin
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    is_wr_d = is_wr_q;
    rd_d    = rd_q;
    so_d    = so_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;

    shift_en = sclk_rise && (state_q == ST_CMD || state_q == ST_ADDR ||
                             (state_q == ST_WDATA && cnt_q != 6'd32));
    if (shift_en) begin
      sr_d  = {sr_q[30:0], si_s};
      cnt_d = cnt_q + 6'd1;
    end
    // Each phase counts its own bits from zero.
    if (state_d != state_q) cnt_d = '0;

    if (state_q == ST_CMD && state_d == ST_ADDR)
      is_wr_d = (cmd_w == SPI_WRITE_CMD);
    if (state_q == ST_ADDR && (state_d == ST_WDATA || state_d == ST_RFETCH))
      addr_d = {sr_q[ADDR_W-2:0], si_s};
    if (state_q == ST_WDATA && state_d == ST_COMMIT) begin
      wdata_d = walign(sr_q, cnt_q);
      wstrb_d = wstrb_of(cnt_q[5:3]);
    end

    if (state_q == ST_RFETCH && mem_ack_i) begin
      rd_d = mem_rdata_i;
      // Ack landing on the deadline edge still makes it in time.
      if (sclk_fall) begin
        so_d = mem_rdata_i[31];
        rd_d = {mem_rdata_i[30:0], 1'b0};
        oe_d = 1'b1;
      end
    end else if (state_q == ST_RFETCH && sclk_fall) begin
      so_d = 1'b0;
      oe_d = 1'b1;
    end
    if (state_q == ST_RDATA && sclk_fall) begin
      so_d = rd_q[31];
      rd_d = {rd_q[30:0], 1'b0};
      oe_d = 1'b1;
    end

    if (ce_fall || state_q == ST_IDLE) begin
      so_d = 1'b0;
      oe_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      sr_q      <= '0;
      is_wr_q   <= 1'b0;
      rd_q      <= '0;
      so_q      <= 1'b0;
      oe_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      is_wr_q   <= is_wr_d;
      rd_q      <= rd_d;
      so_q      <= so_d;
      oe_q      <= oe_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign so_o        = so_q & oe_q;
  assign so_oe_o     = oe_q;
  assign mem_req_o   = mem_req;
  assign mem_we_o    = mem_we;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_target.sv
// Directed bench for spi_sram_target: writes, partial write, read, bad command, abort, late ack + reset.
module tb_spi_sram_target;
  import spi_sram_pkg::*;

  localparam int H = 6;  // sclk half period in clk cycles

  logic        clk = 1'b0, reset = 1'b1;
  logic        sclk = 1'b0, ce = 1'b0, si = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        so, so_oe, mem_req, mem_we, cmd_err;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  spi_sram_target #(.ADDR_W(24), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .reset_i(reset), .sclk_i(sclk), .ce_i(ce), .si_i(si),
    .so_o(so), .so_oe_o(so_oe), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .cmd_err_o(cmd_err));

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Bus monitor: completed handshakes, error pulses, cycles with so high.
  int          hs_cnt = 0, err_cnt = 0, so_ones = 0;
  logic        cap_we = 1'b0;
  logic [23:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      hs_cnt    <= hs_cnt + 1;
      cap_we    <= mem_we;
      cap_addr  <= mem_addr;
      cap_wdata <= mem_wdata;
      cap_wstrb <= mem_wstrb;
    end
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (so)      so_ones <= so_ones + 1;
  end

  // Memory responder: one-cycle ack the cycle after a request is seen.
  logic        ack_en = 1'b1, ack_force = 1'b0;
  logic [31:0] rd_word = '0;
  initial forever begin
    @(negedge clk);
    if (ack_force) mem_ack = 1'b1;
    else if (ack_en && mem_req && !mem_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = rd_word;
    end else mem_ack = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [31:0] v, input int nb, output logic [31:0] got);
    got = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      si = v[i];
      tick(H);
      got[i] = so;
      sclk = 1'b1;
      tick(H);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_on;
    ce = 1'b1;
    tick(8);
  endtask

  task automatic cs_off;
    tick(H);
    ce = 1'b0;
    tick(20);
  endtask

  logic [31:0] g, g2;
  int h0, e0, s0;

  initial begin
    // Reset state
    tick(3);
    chk("rst_so",      {so_oe, so}, 0);
    chk("rst_req",     {mem_req, mem_we, cmd_err}, 0);
    chk("rst_addr",    mem_addr, 0);
    chk("rst_wdata",   mem_wdata, 0);
    chk("rst_wstrb",   mem_wstrb, 0);
    reset = 1'b0;
    tick(2);

    // Full 32-bit write
    h0 = hs_cnt;
    cs_on;
    xfer(SPI_WRITE_CMD, 8, g);
    xfer(32'h000104, 24, g);
    xfer(32'hDEADBEEF, 32, g);
    cs_off;
    chk("w32_hs",    hs_cnt - h0, 1);
    chk("w32_we",    cap_we, 1);
    chk("w32_addr",  cap_addr, 32'h000104);
    chk("w32_wdata", cap_wdata, 32'hDEADBEEF);
    chk("w32_wstrb", cap_wstrb, 4'b1111);
    chk("w32_idle",  mem_req, 0);

    // One byte plus a trailing partial byte
    h0 = hs_cnt;
    cs_on;
    xfer(SPI_WRITE_CMD, 8, g);
    xfer(32'h000200, 24, g);
    xfer(32'hA5, 8, g);
    xfer(32'h5, 3, g);
    cs_off;
    chk("w8_hs",    hs_cnt - h0, 1);
    chk("w8_addr",  cap_addr, 32'h000200);
    chk("w8_wdata", cap_wdata, 32'hA500_0000);
    chk("w8_wstrb", cap_wstrb, 4'b1000);

    // Read with prompt ack
    rd_word = 32'h12345678;
    h0 = hs_cnt; e0 = err_cnt;
    cs_on;
    xfer(SPI_READ_CMD, 8, g);
    xfer(32'h000010, 24, g);
    xfer(32'h0, 32, g);
    chk("rd_oe", so_oe, 1);
    s0 = so_ones;
    xfer(32'h0, 8, g2);
    chk("rd_tail_bits", g2, 0);
    chk("rd_tail_so",   so_ones - s0, 0);
    cs_off;
    chk("rd_data",  g, 32'h12345678);
    chk("rd_hs",    hs_cnt - h0, 1);
    chk("rd_we",    cap_we, 0);
    chk("rd_addr",  cap_addr, 32'h000010);
    chk("rd_oe_off", so_oe, 0);
    chk("rd_noerr", err_cnt - e0, 0);

    // Unknown command
    h0 = hs_cnt; e0 = err_cnt; s0 = so_ones;
    cs_on;
    xfer(32'h9F, 8, g);
    xfer(32'hFFFF, 16, g);
    cs_off;
    chk("bad_err", err_cnt - e0, 1);
    chk("bad_hs",  hs_cnt - h0, 0);
    chk("bad_so",  so_ones - s0, 0);

    // Abort inside the address, then a normal 2-byte write
    h0 = hs_cnt;
    cs_on;
    xfer(SPI_WRITE_CMD, 8, g);
    xfer(32'hABC, 12, g);
    cs_off;
    chk("abort_hs",  hs_cnt - h0, 0);
    chk("abort_req", mem_req, 0);
    h0 = hs_cnt;
    cs_on;
    xfer(SPI_WRITE_CMD, 8, g);
    xfer(32'h000ABC, 24, g);
    xfer(32'h5566, 16, g);
    cs_off;
    chk("w16_hs",    hs_cnt - h0, 1);
    chk("w16_addr",  cap_addr, 32'h000ABC);
    chk("w16_wdata", cap_wdata, 32'h5566_0000);
    chk("w16_wstrb", cap_wstrb, 4'b1100);

    // Read with ack withheld past the deadline, then reset mid-fetch
    ack_en = 1'b0;
    h0 = hs_cnt; e0 = err_cnt;
    cs_on;
    xfer(SPI_READ_CMD, 8, g);
    xfer(32'h000020, 24, g);
    tick(8);
    chk("late_req", mem_req, 1);
    chk("late_err", err_cnt - e0, 1);
    chk("late_so",  so, 0);
    reset = 1'b1; ce = 1'b0; sclk = 1'b0;
    tick(1);
    chk("mid_rst_req",  {mem_req, mem_we, cmd_err}, 0);
    chk("mid_rst_so",   {so_oe, so}, 0);
    chk("mid_rst_regs", {mem_addr, mem_wstrb}, 0);
    chk("mid_rst_wd",   mem_wdata, 0);
    reset = 1'b0;
    ack_force = 1'b1;
    tick(6);
    ack_force = 1'b0;
    chk("rst_noack_hs",  hs_cnt - h0, 0);
    chk("rst_noack_req", mem_req, 0);

    // Target is back in IDLE and serves a fresh write
    ack_en = 1'b1;
    tick(2);
    h0 = hs_cnt;
    cs_on;
    xfer(SPI_WRITE_CMD, 8, g);
    xfer(32'h000333, 24, g);
    xfer(32'h77, 8, g);
    cs_off;
    chk("post_hs",    hs_cnt - h0, 1);
    chk("post_wdata", cap_wdata, 32'h7700_0000);
    chk("post_wstrb", cap_wstrb, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
